flash_bus_arbiter: RTL and testbench
====================================

Name: flash_bus_arbiter

Overview:
- Shares one Avalon-MM flash/ROM slave port (EPCQ controller) between the ibex instruction port and the ibex data port.
- Each requester uses the ibex req/gnt/rvalid protocol. The block converts byte addresses to word addresses and optionally byte-swaps read and write data.
- Only one transaction is outstanding at a time. If the slave never returns read data, a watchdog answers with an error.
- Sits between ibex_core and the flash subsystem and runs on the gated system clock.

Parameters:
- AddrWidth, 24, width of avm_address_o (word address).
- SwapBytes, 1'b1, 1 = reverse byte order of avm_readdata_i and data_wdata_i (byte 0 to byte 3); byte enables are reversed to match.
- TimeoutCycles, 256, cycles a read may wait in WAIT_RD before the error response; must be ≥ 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  instruction fetch request
- instr_addr_i  in  32  instruction byte address
- instr_gnt_o  out  1  instruction request accepted
- instr_rvalid_o  out  1  instruction response valid (1-cycle pulse)
- instr_rdata_o  out  32  instruction read data
- instr_err_o  out  1  instruction response error (qualified by rvalid)
- data_req_i  in  1  data request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid (1-cycle pulse)
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data response error
- avm_address_o  out  AddrWidth  word address = addr[AddrWidth+1:2]
- avm_read_o  out  1  Avalon read
- avm_write_o  out  1  Avalon write
- avm_byteenable_o  out  4  Avalon byte enables
- avm_writedata_o  out  32  Avalon write data
- avm_waitrequest_i  in  1  slave stall
- avm_readdata_i  in  32  read data
- avm_readdatavalid_i  in  1  read data valid
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE, last_owner = DATA, stale = 0, timeout counter = 0. All outputs are 0 on reset, including rdata and avm_address_o.
- State IDLE:
  - gnt is combinational. With one requester, grant that requester. With both requesting, grant the one that is not last_owner (round-robin), so after reset instr wins the first tie.
  - On the granting edge, capture owner, we (instr forces we = 0, be = 4'hF), be, address and wdata. Update last_owner and go to CMD.
  - No gnt in any other state.
- State CMD:
  - avm_read_o = !we and avm_write_o = we, both registered and asserted for the whole state. Address, byteenable and writedata are held stable.
  - On an edge with waitrequest = 0: a read goes to WAIT_RD with the counter cleared; a write goes to IDLE and pulses the owner's rvalid in the next cycle with err = 0 and rdata = 0.
- State WAIT_RD:
  - avm_read_o and avm_write_o are 0.
  - On readdatavalid: register the (swapped) readdata into the owner's rdata, pulse the owner's rvalid for one cycle with err = 0, go to IDLE.
  - Otherwise the counter increments. When it reaches TimeoutCycles-1 without readdatavalid: pulse rvalid with err = 1 and rdata = 0, set stale, go to DRAIN.
- State DRAIN:
  - No gnt, avm idle.
  - The first readdatavalid is discarded; clear stale and go to IDLE.
  - If a further TimeoutCycles elapse with no readdatavalid, clear stale and go to IDLE anyway.
- Minimum read latency: gnt at cycle 0, avm_read_o in cycle 1. With no waitrequest and readdatavalid in cycle 2, rvalid is seen in cycle 3.
- Minimum write latency: gnt at cycle 0, rvalid in cycle 2.
- rdata of the non-owner port holds its last value. An rvalid is never asserted on both ports in the same cycle.
- readdatavalid outside WAIT_RD/DRAIN is ignored.
- Requests arriving while not in IDLE wait; req is held by the ibex protocol.
- Asynchronous reset mid-transaction returns everything to reset values immediately; a pending response is not delivered.

Test Plan:
- Instr read 0x0000_0080, slave with no wait, readdata 0x1122_3344 one cycle after accept, SwapBytes = 1 -> avm_address_o = 0x20; instr_rvalid_o in cycle 3 with instr_rdata_o = 0x4433_2211, err = 0.
- Data write 0x100, be = 4'b0011, wdata 0xAABB_CCDD, waitrequest high for 3 cycles -> avm_write_o high for 4 cycles; byteenable = 4'b1100; writedata = 0xDDCC_BBAA; data_rvalid_o one cycle after the accepting edge.
- instr_req and data_req both held high for 4 transactions -> grants alternate instr, data, instr, data; exactly one gnt per transaction.
- Read with no readdatavalid, TimeoutCycles = 8 -> rvalid with err = 1 and rdata = 0 after 8 WAIT_RD cycles. A late readdatavalid in DRAIN is discarded and the next request is granted afterwards.
- Reset asserted during WAIT_RD -> outputs 0 immediately. After release, a new instr request is granted in IDLE and no stale rvalid appears.
- readdatavalid pulsed while in IDLE -> no rvalid on either port, and state is unchanged.

Source files
------------

// File: rtl/flash_bus_arbiter.sv
`default_nettype none
// ============================================================================
// flash_bus_arbiter
// Round-robin arbiter sharing one Avalon-MM flash slave between the ibex
// instruction and data ports, with optional byte swap and a read watchdog.
// Revision: 1.0
// ============================================================================
module flash_bus_arbiter #(
  parameter int unsigned AddrWidth     = 24,
  parameter bit          SwapBytes     = 1'b1,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic [AddrWidth-1:0] avm_address_o,
  output logic                 avm_read_o,
  output logic                 avm_write_o,
  output logic [3:0]           avm_byteenable_o,
  output logic [31:0]          avm_writedata_o,
  input  logic                 avm_waitrequest_i,
  input  logic [31:0]          avm_readdata_i,
  input  logic                 avm_readdatavalid_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WAIT_RD = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam logic        OWNER_INSTR = 1'b0;
  localparam logic        OWNER_DATA  = 1'b1;
  localparam int unsigned CntWidth    = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  function automatic logic [31:0] swap_word(input logic [31:0] w);
    return SwapBytes ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  function automatic logic [3:0] swap_be(input logic [3:0] b);
    return SwapBytes ? {b[0], b[1], b[2], b[3]} : b;
  endfunction

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_owner_q, last_owner_d;
  logic                   we_q, we_d;
  logic                   stale_q, stale_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [AddrWidth-1:0]   avm_address_q, avm_address_d;
  logic                   avm_read_q, avm_read_d;
  logic                   avm_write_q, avm_write_d;
  logic [3:0]             avm_be_q, avm_be_d;
  logic [31:0]            avm_wdata_q, avm_wdata_d;
  logic                   instr_rvalid_q, instr_rvalid_d;
  logic                   instr_err_q, instr_err_d;
  logic [31:0]            instr_rdata_q, instr_rdata_d;
  logic                   data_rvalid_q, data_rvalid_d;
  logic                   data_err_q, data_err_d;
  logic [31:0]            data_rdata_q, data_rdata_d;

  logic                   rsp_fire;
  logic                   rsp_err;
  logic [31:0]            rsp_data;
  logic                   grant_we;
  logic                   addr_unused;

  // Round-robin tie break: the requester that did not own the last transfer wins.
  assign instr_gnt_o = (state_q == IDLE) && instr_req_i &&
                       (!data_req_i || (last_owner_q == OWNER_DATA));
  assign data_gnt_o  = (state_q == IDLE) && data_req_i &&
                       (!instr_req_i || (last_owner_q == OWNER_INSTR));
  assign grant_we    = data_gnt_o && data_we_i;
  assign addr_unused = ^{instr_addr_i, data_addr_i};

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    we_d           = we_q;
    stale_d        = stale_q;
    cnt_d          = cnt_q;
    avm_address_d  = avm_address_q;
    avm_read_d     = avm_read_q;
    avm_write_d    = avm_write_q;
    avm_be_d       = avm_be_q;
    avm_wdata_d    = avm_wdata_q;
    instr_rvalid_d = 1'b0;
    instr_err_d    = 1'b0;
    instr_rdata_d  = instr_rdata_q;
    data_rvalid_d  = 1'b0;
    data_err_d     = 1'b0;
    data_rdata_d   = data_rdata_q;
    rsp_fire       = 1'b0;
    rsp_err        = 1'b0;
    rsp_data       = '0;

    case (state_q)
      IDLE: begin
        if (instr_gnt_o || data_gnt_o) begin
          owner_d       = data_gnt_o ? OWNER_DATA : OWNER_INSTR;
          last_owner_d  = data_gnt_o ? OWNER_DATA : OWNER_INSTR;
          we_d          = grant_we;
          avm_address_d = data_gnt_o ? data_addr_i[AddrWidth+1:2]
                                     : instr_addr_i[AddrWidth+1:2];
          avm_be_d      = data_gnt_o ? swap_be(data_be_i) : 4'hF;
          avm_wdata_d   = data_gnt_o ? swap_word(data_wdata_i) : avm_wdata_q;
          avm_read_d    = !grant_we;
          avm_write_d   = grant_we;
          state_d       = CMD;
        end
      end
      CMD: begin
        if (!avm_waitrequest_i) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (we_q) begin
            rsp_fire = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid_i) begin
          rsp_fire = 1'b1;
          rsp_data = swap_word(avm_readdata_i);
          state_d  = IDLE;
        end else if (cnt_q == CntLast) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          stale_d  = 1'b1;
          cnt_d    = '0;
          state_d  = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // The late beat of the abandoned read is swallowed here.
        if ((avm_readdatavalid_i && stale_q) || (cnt_q == CntLast)) begin
          stale_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_fire) begin
      if (owner_q == OWNER_DATA) begin
        data_rvalid_d = 1'b1;
        data_err_d    = rsp_err;
        data_rdata_d  = rsp_data;
      end else begin
        instr_rvalid_d = 1'b1;
        instr_err_d    = rsp_err;
        instr_rdata_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_INSTR;
      last_owner_q   <= OWNER_DATA;
      we_q           <= 1'b0;
      stale_q        <= 1'b0;
      cnt_q          <= '0;
      avm_address_q  <= '0;
      avm_read_q     <= 1'b0;
      avm_write_q    <= 1'b0;
      avm_be_q       <= 4'h0;
      avm_wdata_q    <= '0;
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      we_q           <= we_d;
      stale_q        <= stale_d;
      cnt_q          <= cnt_d;
      avm_address_q  <= avm_address_d;
      avm_read_q     <= avm_read_d;
      avm_write_q    <= avm_write_d;
      avm_be_q       <= avm_be_d;
      avm_wdata_q    <= avm_wdata_d;
      instr_rvalid_q <= instr_rvalid_d;
      instr_err_q    <= instr_err_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rvalid_q  <= data_rvalid_d;
      data_err_q     <= data_err_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign avm_address_o    = avm_address_q;
  assign avm_read_o       = avm_read_q;
  assign avm_write_o      = avm_write_q;
  assign avm_byteenable_o = avm_be_q;
  assign avm_writedata_o  = avm_wdata_q;
  assign instr_rvalid_o   = instr_rvalid_q;
  assign instr_err_o      = instr_err_q;
  assign instr_rdata_o    = instr_rdata_q;
  assign data_rvalid_o    = data_rvalid_q;
  assign data_err_o       = data_err_q;
  assign data_rdata_o     = data_rdata_q;
  assign busy_o           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_flash_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_flash_bus_arbiter
// Directed bench with a transaction-level reference model checked every cycle.
// Revision: 1.0
// ============================================================================
module tb_flash_bus_arbiter;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_i = 0;
  logic [31:0] instr_addr_i = 0;
  logic        data_req_i = 0, data_we_i = 0;
  logic [3:0]  data_be_i = 0;
  logic [31:0] data_addr_i = 0, data_wdata_i = 0;
  logic        avm_waitrequest_i = 0, avm_readdatavalid_i = 0;
  logic [31:0] avm_readdata_i = 0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [23:0] avm_address_o;
  logic        avm_read_o, avm_write_o, busy_o;
  logic [3:0]  avm_byteenable_o;
  logic [31:0] avm_writedata_o;

  always #5 clk = ~clk;

  flash_bus_arbiter #(.AddrWidth(24), .SwapBytes(1'b1), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_byteenable_o(avm_byteenable_o), .avm_writedata_o(avm_writedata_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
    .avm_readdatavalid_i(avm_readdatavalid_i), .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] bit_rev4(input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = b[3-i];
    return r;
  endfunction

  // Reference model: one transaction in flight, tracked as plain flags/counters.
  bit          m_busy, m_cmd, m_drain, m_we, m_owner, m_last_data;
  int          m_cnt;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        e_i_rv, e_d_rv, e_i_err, e_d_err;
  logic [31:0] e_i_rdata, e_d_rdata;
  bit          mg_i, mg_d, cg_i, cg_d;

  task model_respond(input bit err, input logic [31:0] d);
    if (m_owner) begin e_d_rv = 1; e_d_err = err; e_d_rdata = d; end
    else begin e_i_rv = 1; e_i_err = err; e_i_rdata = d; end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_cmd = 0; m_drain = 0; m_we = 0; m_owner = 0; m_last_data = 1; m_cnt = 0;
      m_addr = 0; m_wdata = 0; m_be = 0;
      e_i_rv = 0; e_d_rv = 0; e_i_err = 0; e_d_err = 0; e_i_rdata = 0; e_d_rdata = 0;
    end else begin
      e_i_rv = 0; e_d_rv = 0; e_i_err = 0; e_d_err = 0;
      if (!m_busy) begin
        mg_i = instr_req_i && (!data_req_i || m_last_data);
        mg_d = data_req_i && (!instr_req_i || !m_last_data);
        if (mg_i || mg_d) begin
          m_busy = 1; m_cmd = 1; m_owner = mg_d; m_last_data = mg_d;
          m_we   = mg_d && data_we_i;
          m_addr = mg_d ? data_addr_i : instr_addr_i;
          m_be   = mg_d ? data_be_i : 4'hF;
          if (mg_d) m_wdata = data_wdata_i;
        end
      end else if (m_cmd) begin
        if (!avm_waitrequest_i) begin
          m_cmd = 0;
          if (m_we) begin m_busy = 0; model_respond(0, 32'h0); end
          else m_cnt = 0;
        end
      end else if (!m_drain) begin
        if (avm_readdatavalid_i) begin m_busy = 0; model_respond(0, byte_rev(avm_readdata_i)); end
        else if (m_cnt == T - 1) begin model_respond(1, 32'h0); m_drain = 1; m_cnt = 0; end
        else m_cnt++;
      end else begin
        if (avm_readdatavalid_i || m_cnt == T - 1) begin m_drain = 0; m_busy = 0; end
        else m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    cg_i = !m_busy && instr_req_i && (!data_req_i || m_last_data);
    cg_d = !m_busy && data_req_i && (!instr_req_i || !m_last_data);
    check("instr_gnt", instr_gnt_o, cg_i);
    check("data_gnt", data_gnt_o, cg_d);
    check("busy", busy_o, m_busy);
    check("instr_rvalid", instr_rvalid_o, e_i_rv);
    check("data_rvalid", data_rvalid_o, e_d_rv);
    check("instr_rdata", instr_rdata_o, e_i_rdata);
    check("data_rdata", data_rdata_o, e_d_rdata);
    check("avm_read", avm_read_o, m_cmd && !m_we);
    check("avm_write", avm_write_o, m_cmd && m_we);
    if (e_i_rv) check("instr_err", instr_err_o, e_i_err);
    if (e_d_rv) check("data_err", data_err_o, e_d_err);
    if (!rst_n || m_cmd) begin
      check("avm_address", avm_address_o, m_addr[25:2]);
      check("avm_byteenable", avm_byteenable_o, bit_rev4(m_be));
    end
    if (!rst_n || (m_cmd && m_we)) check("avm_writedata", avm_writedata_o, byte_rev(m_wdata));
  end

  // Optional auto-responding slave: read data one cycle after acceptance.
  bit   auto_slave = 0;
  logic slave_acc;
  int   slave_seq = 0;
  always @(posedge clk) begin
    slave_acc = auto_slave && avm_read_o && !avm_waitrequest_i;
    #1;
    if (auto_slave) begin
      avm_readdatavalid_i = slave_acc;
      if (slave_acc) begin avm_readdata_i = 32'hC0DE_0000 + slave_seq; slave_seq++; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, rv_cyc, gnt_cyc, drv_cyc, n_rv;
    int gq[$];
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_addr", avm_address_o, 0);
    check("reset_be", avm_byteenable_o, 0);
    check("reset_rdata", instr_rdata_o, 0);
    rst_n = 1'b1;
    step(); step();

    // Instruction read, no wait states
    instr_req_i = 1; instr_addr_i = 32'h0000_0080; #1;
    check("t1_gnt", instr_gnt_o, 1);
    step(); instr_req_i = 0; #1;
    check("t1_avm_read", avm_read_o, 1);
    check("t1_avm_address", avm_address_o, 32'h20);
    step(); avm_readdatavalid_i = 1; avm_readdata_i = 32'h1122_3344;
    step(); avm_readdatavalid_i = 0; #1;
    check("t1_rvalid", instr_rvalid_o, 1);
    check("t1_rdata", instr_rdata_o, 32'h4433_2211);
    check("t1_err", instr_err_o, 0);
    step(); #1;
    check("t1_rvalid_pulse", instr_rvalid_o, 0);

    // Data write with three wait states
    data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h100;
    data_wdata_i = 32'hAABB_CCDD; avm_waitrequest_i = 1; #1;
    check("t2_gnt", data_gnt_o, 1);
    n_wr = 0; rv_cyc = -1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      step();
      if (cyc == 1) data_req_i = 0;
      if (cyc == 4) avm_waitrequest_i = 0;
      #1;
      if (cyc == 1) begin
        check("t2_be", avm_byteenable_o, 4'b1100);
        check("t2_wdata", avm_writedata_o, 32'hDDCC_BBAA);
        check("t2_addr", avm_address_o, 32'h40);
      end
      if (avm_write_o) n_wr++;
      if (data_rvalid_o) begin
        rv_cyc = cyc;
        check("t2_err", data_err_o, 0);
      end
    end
    check("t2_write_cycles", n_wr, 4);
    check("t2_rvalid_cycle", rv_cyc, 5);
    data_we_i = 0; data_be_i = 4'hF;

    // Both requesters contend for four transfers
    auto_slave = 1;
    instr_addr_i = 32'h300; data_addr_i = 32'h400;
    instr_req_i = 1; data_req_i = 1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (instr_gnt_o && data_gnt_o) check("t3_double_gnt", 1, 0);
      if (instr_gnt_o) gq.push_back(0);
      if (data_gnt_o) gq.push_back(1);
      step();
      if (gq.size() >= 4) break;
    end
    instr_req_i = 0; data_req_i = 0;
    check("t3_gnt_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++) check("t3_gnt_order", gq[k], exp_order[k]);
    for (int k = 0; k < 20 && busy_o; k++) step();
    check("t3_idle", busy_o, 0);
    step(); step();
    auto_slave = 0; avm_readdatavalid_i = 0;

    // Read timeout, late beat swallowed in drain, then a data read
    instr_req_i = 1; instr_addr_i = 32'h200; #1;
    check("t4_gnt", instr_gnt_o, 1);
    rv_cyc = -1; gnt_cyc = -1; drv_cyc = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      step();
      if (cyc == 1) instr_req_i = 0;
      if (cyc == 11) begin data_req_i = 1; data_we_i = 0; data_addr_i = 32'h500; end
      if (cyc == 12) begin avm_readdatavalid_i = 1; avm_readdata_i = 32'hDEAD_BEEF; end
      if (cyc == 13) avm_readdatavalid_i = 0;
      if (cyc == 14) auto_slave = 1;
      if (gnt_cyc >= 0 && cyc == gnt_cyc + 1) data_req_i = 0;
      #1;
      if (instr_rvalid_o) begin
        rv_cyc = cyc;
        check("t4_err", instr_err_o, 1);
        check("t4_rdata", instr_rdata_o, 0);
      end
      if (data_gnt_o && gnt_cyc < 0) gnt_cyc = cyc;
      if (data_rvalid_o && drv_cyc < 0) drv_cyc = cyc;
    end
    check("t4_timeout_cycle", rv_cyc, 10);
    check("t4_next_gnt_cycle", gnt_cyc, 13);
    check("t4_data_rvalid_cycle", drv_cyc, 16);
    auto_slave = 0; step(); avm_readdatavalid_i = 0; step();

    // Asynchronous reset while waiting for read data
    instr_req_i = 1; instr_addr_i = 32'h600; #1;
    check("t5_gnt", instr_gnt_o, 1);
    step(); instr_req_i = 0;
    step(); step();
    rst_n = 1'b0; #1;
    check("t5_busy", busy_o, 0);
    check("t5_avm_read", avm_read_o, 0);
    check("t5_addr", avm_address_o, 0);
    check("t5_instr_rdata", instr_rdata_o, 0);
    check("t5_data_rdata", data_rdata_o, 0);
    step(); step();
    rst_n = 1'b1;
    n_rv = 0;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      if (instr_rvalid_o || data_rvalid_o) n_rv++;
    end
    check("t5_no_stale_rvalid", n_rv, 0);
    instr_req_i = 1; instr_addr_i = 32'h700; #1;
    check("t5_regnt", instr_gnt_o, 1);
    step(); instr_req_i = 0;
    step(); avm_readdatavalid_i = 1; avm_readdata_i = 32'hA1B2_C3D4;
    step(); avm_readdatavalid_i = 0; #1;
    check("t5_rvalid", instr_rvalid_o, 1);
    check("t5_rdata", instr_rdata_o, 32'hD4C3_B2A1);

    // Stray readdatavalid while idle
    step(); step();
    avm_readdatavalid_i = 1; avm_readdata_i = 32'h5555_5555; #1;
    check("t6_busy_before", busy_o, 0);
    step(); avm_readdatavalid_i = 0; #1;
    check("t6_instr_rvalid", instr_rvalid_o, 0);
    check("t6_data_rvalid", data_rvalid_o, 0);
    check("t6_busy_after", busy_o, 0);
    check("t6_rdata_hold", instr_rdata_o, 32'hD4C3_B2A1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
